clock_time_ctrl: RTL and testbench

- Timekeeping and set-mode controller for the digital clock.
- Consumes a single-cycle 1 Hz tick enable from the clock divider, plus two debounced, clk-synchronous buttons (mode, increment).
- Sequences run/set modes and owns the hours/minutes/seconds registers.
- Drives the display formatter, including a blink flag for the field being edited.

---
 rtl/clock_time_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Clock timekeeping and set-mode controller; define HOLD_REPEAT_EN for btn_inc auto-repeat.
// All outputs registered, updated on the posedge that samples tick/button edges; no backpressure.
module clock_time_ctrl #(
  parameter int H24          = 1,
  parameter int REPEAT_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [4:0] HOUR_RST = (H24 != 0) ? 5'd0 : 5'd12;

  mode_t      state_q, state_n;
  logic [4:0] hours_q, hours_n;
  logic [5:0] minutes_q, minutes_n;
  logic [5:0] seconds_q, seconds_n;
  logic       blink_q, blink_n;
  logic       prev_mode_q, prev_inc_q;
  logic       mode_edge, inc_edge, inc_req, rep_fire;

  assign mode_edge = btn_mode & ~prev_mode_q;
  assign inc_edge  = btn_inc & ~prev_inc_q;
  assign inc_req   = inc_edge | rep_fire;

  // Out-of-range inputs (never reached) still map back into the legal range.
  function automatic logic [4:0] next_hour(input logic [4:0] h);
    if (H24 != 0) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    else          return (h >= 5'd12) ? 5'd1 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_sixty(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

`ifdef HOLD_REPEAT_EN
  localparam int CW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] RD = CW'(REPEAT_DELAY);

  logic [CW-1:0] hold_cnt_q, hold_cnt_n;
  logic          hold_arm_q, hold_arm_n;

  // Only a hold that began with an edge inside the current set mode may repeat.
  always_comb begin
    hold_cnt_n = hold_cnt_q;
    hold_arm_n = hold_arm_q;
    rep_fire   = 1'b0;
    if (state_q == RUN || mode_edge) begin
      hold_cnt_n = '0;
      hold_arm_n = 1'b0;
    end else if (inc_edge) begin
      hold_cnt_n = '0;
      hold_arm_n = 1'b1;
    end else if (!btn_inc) begin
      hold_cnt_n = '0;
      hold_arm_n = 1'b0;
    end else if (tick && hold_arm_q) begin
      if (hold_cnt_q >= RD) rep_fire = 1'b1;
      else                  hold_cnt_n = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      hold_arm_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_n;
      hold_arm_q <= hold_arm_n;
    end
  end
`else
  // No auto-repeat in this build; the delay parameter has no effect.
  assign rep_fire = (REPEAT_DELAY < 0);
`endif

  always_comb begin
    state_n   = state_q;
    hours_n   = hours_q;
    minutes_n = minutes_q;
    seconds_n = seconds_q;
    blink_n   = blink_q;
    case (state_q)
      RUN: begin
        blink_n = 1'b0;
        if (tick) begin
          seconds_n = next_sixty(seconds_q);
          if (seconds_q >= 6'd59) begin
            minutes_n = next_sixty(minutes_q);
            if (minutes_q >= 6'd59) hours_n = next_hour(hours_q);
          end
        end
        if (mode_edge) state_n = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_edge) begin
          state_n = SET_MIN;
          blink_n = 1'b0;
        end else begin
          if (tick)    blink_n = ~blink_q;
          if (inc_req) hours_n = next_hour(hours_q);
        end
      end
      SET_MIN: begin
        if (mode_edge) begin
          state_n   = RUN;
          seconds_n = 6'd0;
          blink_n   = 1'b0;
        end else begin
          if (tick)    blink_n = ~blink_q;
          if (inc_req) minutes_n = next_sixty(minutes_q);
        end
      end
      default: begin
        state_n = RUN;
        blink_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      hours_q     <= HOUR_RST;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      blink_q     <= 1'b0;
      prev_mode_q <= 1'b1;
      prev_inc_q  <= 1'b1;
    end else begin
      state_q     <= state_n;
      hours_q     <= hours_n;
      minutes_q   <= minutes_n;
      seconds_q   <= seconds_n;
      blink_q     <= blink_n;
      prev_mode_q <= btn_mode;
      prev_inc_q  <= btn_inc;
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign mode    = state_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: 24-hour and 12-hour instances share stimulus and are
// checked every cycle against a time-of-day model, plus directed literal checks.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;

  logic [4:0] h_a, h_b;
  logic [5:0] m_a, m_b, s_a, s_b;
  logic [1:0] md_a, md_b;
  logic       bl_a, bl_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(.H24(1), .REPEAT_DELAY(2)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours(h_a), .minutes(m_a), .seconds(s_a), .mode(md_a), .blink(bl_a)
  );

  clock_time_ctrl #(.H24(0), .REPEAT_DELAY(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours(h_b), .minutes(m_b), .seconds(s_b), .mode(md_b), .blink(bl_b)
  );

  // Reference model: index 0 is the 24-hour instance, index 1 the 12-hour one.
  int mh[2], mm[2], ms[2];
  int mmode, mblink;
  bit pm, pi, me, ie, rep;
  int hcnt;
  bit harm;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mh[0] = 0; mh[1] = 12;
    for (int d = 0; d < 2; d++) begin mm[d] = 0; ms[d] = 0; end
    mmode = 0; mblink = 0; pm = 1; pi = 1; hcnt = 0; harm = 0;
  endtask

  task automatic advance(input int d);
    int t;
    if (d == 0) begin
      t = (mh[0] * 3600 + mm[0] * 60 + ms[0] + 1) % 86400;
      mh[0] = t / 3600;
    end else begin
      t = ((mh[1] % 12) * 3600 + mm[1] * 60 + ms[1] + 1) % 43200;
      mh[1] = (t / 3600 == 0) ? 12 : t / 3600;
    end
    mm[d] = (t / 60) % 60;
    ms[d] = t % 60;
  endtask

  task automatic model_step();
    me = btn_mode && !pm;
    ie = btn_inc && !pi;
    rep = 0;
`ifdef HOLD_REPEAT_EN
    if (mmode == 0 || me) begin harm = 0; hcnt = 0; end
    else if (ie) begin harm = 1; hcnt = 0; end
    else if (!btn_inc) begin harm = 0; hcnt = 0; end
    else if (tick && harm) begin
      if (hcnt >= 2) rep = 1; else hcnt++;
    end
`endif
    for (int d = 0; d < 2; d++) begin
      if (mmode == 0 && tick) advance(d);
      if (mmode == 1 && !me && (ie || rep))
        mh[d] = (d == 0) ? (mh[d] + 1) % 24 : (mh[d] % 12) + 1;
      if (mmode == 2 && !me && (ie || rep)) mm[d] = (mm[d] + 1) % 60;
      if (mmode == 2 && me) ms[d] = 0;
    end
    if (me) begin
      mmode = (mmode + 1) % 3;
      mblink = 0;
    end else if (mmode != 0 && tick) mblink = !mblink;
    pm = btn_mode;
    pi = btn_inc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("hours24", h_a, mh[0]);  chk("hours12", h_b, mh[1]);
      chk("min24", m_a, mm[0]);    chk("min12", m_b, mm[1]);
      chk("sec24", s_a, ms[0]);    chk("sec12", s_b, ms[1]);
      chk("mode24", md_a, mmode);  chk("mode12", md_b, mmode);
      chk("blink24", bl_a, mblink); chk("blink12", bl_b, mblink);
    end
  end

  task automatic step(input logic t, input logic bm, input logic bi);
    tick = t; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode(); step(0, 1, 0); step(0, 0, 0); endtask
  task automatic press_inc(); step(0, 0, 1); step(0, 0, 0); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) step(1, 0, 0); endtask
  task automatic incs(input int n); for (int i = 0; i < n; i++) press_inc(); endtask

  task automatic do_reset();
    step(0, 0, 0);
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
    step(0, 0, 0);
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_hours24", h_a, 0);   chk("rst_hours12", h_b, 12);
    chk("rst_sec", s_a, 0);       chk("rst_mode", md_a, 0);
    chk("rst_blink", bl_a, 0);
    step(0, 0, 0);
    rst_n = 1;
    step(0, 0, 0);

    // Free-running count.
    ticks(61);
    chk("run61_h24", h_a, 0);  chk("run61_m", m_a, 1);  chk("run61_s", s_a, 1);
    chk("run61_h12", h_b, 12); chk("run61_mode", md_a, 0); chk("run61_blink", bl_a, 0);

    // Preload 23:59 and roll over midnight.
    press_mode();
    incs(23);
    chk("set_h23", h_a, 23);   chk("set_h12", h_b, 11);
    press_mode();
    incs(58);
    press_mode();
    chk("preload_m", m_a, 59); chk("preload_s", s_a, 0); chk("preload_mode", md_a, 0);
    ticks(59);
    chk("pre_wrap_s", s_a, 59);
    ticks(1);
    chk("wrap_h24", h_a, 0);   chk("wrap_m", m_a, 0);   chk("wrap_s", s_a, 0);
    chk("wrap_h12", h_b, 12);

    // Set mode: blink, field increments without carry.
    press_mode();
    chk("sh_mode", md_a, 1);
    incs(3);
    chk("sh_h3", h_a, 3);
    step(1, 0, 0);
    chk("blink_on", bl_a, 1);  chk("frozen_s", s_a, 0);
    step(1, 0, 0);
    chk("blink_off", bl_a, 0);
    press_mode();
    chk("sm_mode", md_a, 2);   chk("sm_blink", bl_a, 0);
    incs(59);
    incs(1);
    chk("min_wrap", m_a, 0);   chk("min_nocarry", h_a, 3);

    // Simultaneous tick + mode edge.
    press_mode();
    ticks(17);
    press_mode(); press_mode();
    chk("s17_frozen", s_a, 17);
    step(1, 1, 0);
    chk("clr_mode", md_a, 0);  chk("clr_s", s_a, 0);    chk("clr_blink", bl_a, 0);
    step(0, 0, 0);
    ticks(5);
    step(1, 1, 0);
    chk("adv_s", s_a, 6);      chk("adv_mode", md_a, 1);
    step(0, 0, 0);
    step(0, 1, 1);
    chk("mi_mode", md_a, 2);   chk("mi_h", h_a, 3);    chk("mi_m", m_a, 0);
    step(0, 0, 0);

    // Reset mid-edit, then buttons held through reset release.
    press_mode(); press_mode();
    incs(4);
    chk("edit_h7", h_a, 7);    chk("edit_mode", md_a, 1);
    #2 rst_n = 0;
    #1;
    chk("async_h24", h_a, 0);  chk("async_h12", h_b, 12); chk("async_mode", md_a, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    rst_n = 1;
    step(0, 1, 1);
    step(0, 1, 1);
    chk("held_mode", md_a, 0); chk("held_h", h_a, 0);
    step(0, 0, 0);

    // Hold btn_inc across ticks.
    do_reset();
    press_mode(); press_mode();
    incs(10);
    step(0, 0, 1);
    chk("hold_edge", m_a, 11);
    for (int k = 0; k < 5; k++) begin step(1, 0, 1); step(0, 0, 1); end
`ifdef HOLD_REPEAT_EN
    chk("hold_end", m_a, 14);
`else
    chk("hold_end", m_a, 11);
`endif
    step(0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic t, bm, bi;
      t  = ($urandom_range(0, 3) == 0);
      bm = ($urandom_range(0, 7) == 0) ? ~btn_mode : btn_mode;
      bi = ($urandom_range(0, 4) == 0) ? ~btn_inc : btn_inc;
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 0;
        step(t, bm, bi);
        rst_n = 1;
      end
      step(t, bm, bi);
    end
    step(0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
